mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address width of all address ports.
REQ-002 Parameter: DATA_W, 32, data width; byte-enable width is DATA_W/8.
REQ-003 Clocking and reset SHALL be one clock and an asynchronous, active-high reset. Ports: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-004 if_req  in  1 (enable_t): fetch read request, held until if_rvalid.
REQ-005 if_addr  in  ADDR_W: fetch address.
REQ-006 flush_c_if  in  1 (enable_t): fetch redirect; discards the fetch in flight.
REQ-007 if_rdata  out  DATA_W: fetch data, valid only while if_rvalid.
REQ-008 if_rvalid  out  1 (enable_t): one-cycle fetch completion pulse.
REQ-009 mem_req, mem_we  in  1 each: data access request (held until mem_done) and write flag.
REQ-010 mem_be  in  DATA_W/8; mem_addr  in  ADDR_W; mem_wdata  in  DATA_W: data access attributes.
REQ-011 mem_rdata  out  DATA_W; mem_done  out  1: load data and one-cycle completion pulse.
REQ-012 bus_req, bus_we  out  1; bus_be  out  DATA_W/8; bus_addr  out  ADDR_W; bus_wdata  out  DATA_W: shared memory port.
REQ-013 bus_gnt, bus_rvalid  in  1; bus_rdata  in  DATA_W: port accept and response (write ack also via bus_rvalid).
REQ-014 stall_c_if, stall_c_mem  out  1 (enable_t): pipeline stall requests to the hazard unit.

Function
REQ-015 FSM states SHALL be IDLE, ADDR, and WAIT, with owner register owner ∈ {OWN_IF, OWN_MEM}.
REQ-016 In IDLE, eligible requesters SHALL be: mem_req & ~mem_done; if_req & ~if_rvalid & ~flush_c_if. MEM wins when both are eligible. The winner's attributes are latched into registers and the FSM moves to ADDR next cycle.
REQ-017 In ADDR, bus_req=1 and the bus_* outputs SHALL come from the latched registers and stay stable until bus_gnt. On bus_gnt, the FSM moves to WAIT.
REQ-018 For IF ownership, bus_we=0 and bus_be=all ones.
REQ-019 In WAIT, bus_req=0. On bus_rvalid, bus_rdata is registered into the owner's rdata register and the FSM moves to IDLE. In the following cycle, the owner's done/rvalid pulses for exactly one cycle.
REQ-020 Minimum latency SHALL be 3 cycles from request to done/rvalid (req@0, ADDR+gnt@1, rvalid@2, done@3). Each extra cycle of gnt or rvalid delay adds one cycle.
REQ-021 stall_c_mem SHALL equal mem_req & ~mem_done, and stall_c_if SHALL equal if_req & ~if_rvalid; both are combinational.
REQ-022 flush_c_if while owner=OWN_IF in ADDR or WAIT SHALL set a drop flag. The bus transaction completes normally (bus_req is never withdrawn before gnt). The response is discarded: no if_rvalid, and if_rdata is not updated. The drop flag clears on return to IDLE.
REQ-023 flush_c_if in the same cycle as bus_rvalid SHALL discard that response.
REQ-024 flush_c_if SHALL have no effect on MEM-owned transactions.
REQ-025 bus_rvalid in IDLE or ADDR and bus_gnt outside ADDR SHALL be ignored.
REQ-026 Only one bus transaction SHALL be outstanding at any time.
REQ-027 if_rdata and mem_rdata SHALL hold their last values between pulses.

Reset
REQ-028 rst SHALL force IDLE, owner=OWN_IF, drop=0, all data/address registers=0, and all outputs=0, including during ADDR or WAIT. The transaction in flight is abandoned.
REQ-029 After reset deasserts, arbitration SHALL resume on the first rising edge.

Structure
REQ-030 The shared package SHALL hold arb_state_t (IDLE/ADDR/WAIT), arb_owner_t, enable_t, and ENABLE/DISABLE.
REQ-031 The block SHALL be a single module with no sub-modules. The FSM, latch registers, and response registers are all in mem_arbiter.

Verification
REQ-032 Lone fetch: if_req=1, if_addr=0x100, gnt immediate, rvalid with 0xDEADBEEF on the next cycle -> bus_addr=0x100, bus_we=0; if_rvalid pulses at cycle 3 with if_rdata=0xDEADBEEF; stall_c_if=1 on cycles 0-2.
REQ-033 Simultaneous requests: if_req and mem_req (load at 0x200) at cycle 0 -> MEM served first with mem_done at cycle 3; IF is arbitrated at cycle 3 and if_rvalid arrives at cycle 6.
REQ-034 Store with backpressure: mem_we=1, be=0x3, wdata=0x1234, gnt held low for 4 cycles -> bus_* stay stable in ADDR for all 4 cycles, bus_req=1 throughout, and mem_done arrives 4 cycles later than in the no-backpressure case.
REQ-035 Flush in WAIT: fetch at 0x300 with flush_c_if asserted during WAIT -> bus completes, no if_rvalid, if_rdata unchanged; a new fetch at 0x400 is then issued normally.
REQ-036 Reset mid-WAIT: assert rst with MEM in WAIT -> all outputs 0 immediately; a late bus_rvalid is ignored; no mem_done.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter_pkg
//  Description : Shared types for the fetch/data memory port arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_arbiter_pkg;

    // Arbiter sequencing: pick a winner, present the address, await the response.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } arb_state_t;

    // Which requester owns the transaction currently on the shared port.
    typedef enum logic {
        OWN_IF  = 1'b0,
        OWN_MEM = 1'b1
    } arb_owner_t;

    // Polarity of single-bit request/strobe/stall signals.
    typedef enum logic {
        DISABLE = 1'b0,
        ENABLE  = 1'b1
    } enable_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Arbitrates the instruction-fetch and data-access requesters
//                onto a single memory port. Data accesses win ties; at most
//                one bus transaction is outstanding. A fetch redirect drops an
//                in-flight fetch response without aborting the bus cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    // Instruction fetch requester
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  flush_c_if,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_rvalid,

    // Data access requester
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [DATA_W/8-1:0]   mem_be,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_done,

    // Shared memory port
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [DATA_W/8-1:0]   bus_be,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    input  logic                  bus_gnt,
    input  logic                  bus_rvalid,
    input  logic [DATA_W-1:0]     bus_rdata,

    // Stall requests to the hazard unit
    output logic                  stall_c_if,
    output logic                  stall_c_mem
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state;
    arb_state_t          state_nxt;
    arb_owner_t          owner;
    logic                drop;

    // Attributes of the transaction that won arbitration
    logic                lat_we;
    logic [BE_W-1:0]     lat_be;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;

    // Response registers and completion pulses
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   mem_rdata_reg;
    logic                if_rvalid_reg;
    logic                mem_done_reg;

    // Decoded control
    logic                flush_act;
    logic                mem_elig;
    logic                if_elig;
    logic                grant_mem;
    logic                grant_if;
    logic                take_resp;
    logic                bus_req_c;

    assign flush_act = (flush_c_if == ENABLE);

    // A requester whose completion pulse is showing this cycle is already
    // served; its request is still high only because it drops it next cycle.
    assign mem_elig = mem_req & ~mem_done_reg;
    assign if_elig  = if_req & ~if_rvalid_reg & ~flush_act;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, arbitration and port request strobe.
    always_comb begin
        state_nxt = state;
        grant_mem = 1'b0;
        grant_if  = 1'b0;
        take_resp = 1'b0;
        bus_req_c = 1'b0;
        case (state)
            IDLE: begin
                if (mem_elig) begin
                    grant_mem = 1'b1;
                    state_nxt = ADDR;
                end else if (if_elig) begin
                    grant_if  = 1'b1;
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                bus_req_c = 1'b1;
                if (bus_gnt) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (bus_rvalid) begin
                    take_resp = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Capture the winner's attributes so the port stays stable until granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (grant_mem) begin
            owner     <= OWN_MEM;
            lat_we    <= mem_we;
            lat_be    <= mem_be;
            lat_addr  <= mem_addr;
            lat_wdata <= mem_wdata;
        end else if (grant_if) begin
            owner     <= OWN_IF;
            lat_we    <= 1'b0;
            lat_be    <= {BE_W{1'b1}};
            lat_addr  <= if_addr;
            lat_wdata <= '0;
        end
    end

    // Remember a redirect that hit an in-flight fetch so its response is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop <= 1'b0;
        end else if (state == IDLE || take_resp) begin
            drop <= 1'b0;
        end else if (owner == OWN_IF && flush_act) begin
            drop <= 1'b1;
        end
    end

    // Route the bus response to its owner and raise a one-cycle completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if_rvalid_reg <= 1'b0;
            mem_done_reg  <= 1'b0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
        end else begin
            if_rvalid_reg <= 1'b0;
            mem_done_reg  <= 1'b0;
            if (take_resp) begin
                if (owner == OWN_MEM) begin
                    mem_rdata_reg <= bus_rdata;
                    mem_done_reg  <= 1'b1;
                end else if (!drop && !flush_act) begin
                    // A redirect arriving with the response also kills it.
                    if_rdata_reg  <= bus_rdata;
                    if_rvalid_reg <= 1'b1;
                end
            end
        end
    end

    assign bus_req   = bus_req_c;
    assign bus_we    = lat_we;
    assign bus_be    = lat_be;
    assign bus_addr  = lat_addr;
    assign bus_wdata = lat_wdata;

    assign if_rdata  = if_rdata_reg;
    assign if_rvalid = if_rvalid_reg;
    assign mem_rdata = mem_rdata_reg;
    assign mem_done  = mem_done_reg;

    // Stalls follow the requests directly; reset forces them low with the rest.
    assign stall_c_if  = if_req  & ~if_rvalid_reg & ~rst;
    assign stall_c_mem = mem_req & ~mem_done_reg  & ~rst;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. A transaction-level
//                reference model predicts every output each cycle; directed
//                scenarios are followed by a long randomized run.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BE_W   = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              flush_c_if;
    logic [DATA_W-1:0] if_rdata;
    logic              if_rvalid;
    logic              mem_req;
    logic              mem_we;
    logic [BE_W-1:0]   mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_done;
    logic              bus_req;
    logic              bus_we;
    logic [BE_W-1:0]   bus_be;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [DATA_W-1:0] bus_rdata;
    logic              stall_c_if;
    logic              stall_c_mem;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .flush_c_if(flush_c_if),
        .if_rdata(if_rdata), .if_rvalid(if_rvalid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_done(mem_done),
        .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
        .stall_c_if(stall_c_if), .stall_c_mem(stall_c_mem)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: one outstanding transaction record plus response state.
    logic              m_busy;        // a transaction has been accepted
    logic              m_granted;     // the port has accepted its address
    logic              m_owner_mem;   // transaction belongs to the data side
    logic              m_dropped;     // fetch response must be discarded
    logic              m_we;
    logic [BE_W-1:0]   m_be;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_if_pulse;
    logic              m_mem_pulse;
    logic [DATA_W-1:0] m_if_rdata;
    logic [DATA_W-1:0] m_mem_rdata;

    logic last_if_rvalid;
    logic last_mem_done;
    int   mem_at;
    int   if_at;
    int   done_cnt;
    int   rst_hold;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy      = 1'b0;
        m_granted   = 1'b0;
        m_owner_mem = 1'b0;
        m_dropped   = 1'b0;
        m_we        = 1'b0;
        m_be        = '0;
        m_addr      = '0;
        m_wdata     = '0;
        m_if_pulse  = 1'b0;
        m_mem_pulse = 1'b0;
        m_if_rdata  = '0;
        m_mem_rdata = '0;
    endtask

    task automatic compare_outputs();
        logic e_req;
        if (rst) model_reset();
        e_req = m_busy && !m_granted;
        check("bus_req", 64'(bus_req), 64'(e_req));
        if (e_req || rst) begin
            check("bus_addr", 64'(bus_addr), 64'(m_addr));
            check("bus_we",   64'(bus_we),   64'(m_we));
            check("bus_be",   64'(bus_be),   64'(m_be));
            if (m_owner_mem || rst)
                check("bus_wdata", 64'(bus_wdata), 64'(m_wdata));
        end
        check("if_rvalid",   64'(if_rvalid),   64'(m_if_pulse));
        check("mem_done",    64'(mem_done),    64'(m_mem_pulse));
        check("if_rdata",    64'(if_rdata),    64'(m_if_rdata));
        check("mem_rdata",   64'(mem_rdata),   64'(m_mem_rdata));
        check("stall_c_if",  64'(stall_c_if),  64'(if_req  && !m_if_pulse  && !rst));
        check("stall_c_mem", 64'(stall_c_mem), 64'(mem_req && !m_mem_pulse && !rst));
        last_if_rvalid = m_if_pulse;
        last_mem_done  = m_mem_pulse;
    endtask

    // Apply one clock edge of the arbitration rules to the transaction record.
    task automatic model_advance();
        logic cur_if;
        logic cur_mem;
        if (rst) begin
            model_reset();
            return;
        end
        cur_if      = m_if_pulse;
        cur_mem     = m_mem_pulse;
        m_if_pulse  = 1'b0;
        m_mem_pulse = 1'b0;
        if (!m_busy) begin
            if (mem_req && !cur_mem) begin
                m_busy = 1'b1; m_granted = 1'b0; m_dropped = 1'b0; m_owner_mem = 1'b1;
                m_addr = mem_addr; m_we = mem_we; m_be = mem_be; m_wdata = mem_wdata;
            end else if (if_req && !cur_if && !flush_c_if) begin
                m_busy = 1'b1; m_granted = 1'b0; m_dropped = 1'b0; m_owner_mem = 1'b0;
                m_addr = if_addr; m_we = 1'b0; m_be = '1; m_wdata = '0;
            end
        end else begin
            if (!m_owner_mem && flush_c_if) m_dropped = 1'b1;
            if (!m_granted) begin
                if (bus_gnt) m_granted = 1'b1;
            end else if (bus_rvalid) begin
                m_busy = 1'b0;
                if (m_owner_mem) begin
                    m_mem_rdata = bus_rdata;
                    m_mem_pulse = 1'b1;
                end else if (!m_dropped) begin
                    m_if_rdata = bus_rdata;
                    m_if_pulse = 1'b1;
                end
            end
        end
    endtask

    // Inputs are set just after a rising edge; outputs are compared on the falling edge.
    task automatic run_cycle();
        @(negedge clk);
        compare_outputs();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0; flush_c_if = 1'b0;
        mem_req = 1'b0; mem_we = 1'b0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    endtask

    // Cooperative memory: grants after gnt_delay address cycles, responds after
    // rv_delay wait cycles, rdata = rdata_base + cycle index. Requests drop the
    // cycle after their completion pulse. Returns pulse cycles (-1 if none).
    task automatic run_scenario(input int gnt_delay, input int rv_delay, input int flushes,
                                input logic [ADDR_W-1:0] redirect,
                                input logic [DATA_W-1:0] rdata_base);
        int addr_cycles = 0;
        int wait_cycles = 0;
        int fl = flushes;
        mem_at = -1;
        if_at  = -1;
        for (int c = 0; c < 40; c++) begin
            if (!(m_busy && !m_granted)) addr_cycles = 0;
            if (!(m_busy && m_granted))  wait_cycles = 0;
            bus_gnt    = m_busy && !m_granted && (addr_cycles >= gnt_delay);
            bus_rvalid = m_busy && m_granted && (wait_cycles >= rv_delay);
            bus_rdata  = rdata_base + DATA_W'(c);
            flush_c_if = 1'b0;
            if (fl > 0 && m_busy && m_granted && !m_owner_mem) begin
                flush_c_if = 1'b1;
                if_addr    = redirect;
                fl--;
            end
            if (m_busy && !m_granted) addr_cycles++;
            if (m_busy && m_granted)  wait_cycles++;
            run_cycle();
            if (last_mem_done && mem_at < 0) mem_at = c;
            if (last_if_rvalid && if_at < 0) if_at = c;
            if (last_mem_done)  mem_req = 1'b0;
            if (last_if_rvalid) if_req  = 1'b0;
            if (!mem_req && !if_req) break;
        end
        idle_inputs();
    endtask

    initial begin
        model_reset();
        idle_inputs();
        last_if_rvalid = 1'b0;
        last_mem_done  = 1'b0;
        rst_hold = 0;
        rst = 1'b1;
        run_cycle();
        run_cycle();
        rst = 1'b0;

        // Lone fetch: response lands on cycle 2 carrying 0xDEADBEEF.
        if_req = 1'b1; if_addr = 32'h100;
        run_scenario(0, 0, 0, '0, 32'hDEADBEED);
        check("lone_fetch_latency", 64'(if_at), 64'(3));
        check("lone_fetch_rdata", 64'(if_rdata), 64'(32'hDEADBEEF));

        // Simultaneous requests: data side first, fetch follows.
        mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h200;
        if_req = 1'b1; if_addr = 32'h104;
        run_scenario(0, 0, 0, '0, 32'h1111_0000);
        check("simul_mem_latency", 64'(mem_at), 64'(3));
        check("simul_if_latency",  64'(if_at),  64'(6));

        // Store with the grant held off for four cycles.
        mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'h3; mem_addr = 32'h600; mem_wdata = 32'h1234;
        run_scenario(4, 0, 0, '0, 32'h2222_0000);
        check("store_bp_latency", 64'(mem_at), 64'(7));

        // Redirect during WAIT: first response discarded, redirected fetch served.
        if_req = 1'b1; if_addr = 32'h300;
        run_scenario(0, 2, 1, 32'h400, 32'h5000_0000);
        check("flush_if_latency", 64'(if_at), 64'(10));
        check("flush_if_rdata", 64'(if_rdata), 64'(32'h5000_0009));

        // Reset while a load sits in WAIT.
        mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h500;
        run_cycle();
        bus_gnt = 1'b1;
        run_cycle();
        bus_gnt = 1'b0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("rst_wait_bus_req",   64'(bus_req),     64'(0));
        check("rst_wait_bus_addr",  64'(bus_addr),    64'(0));
        check("rst_wait_mem_done",  64'(mem_done),    64'(0));
        check("rst_wait_mem_rdata", 64'(mem_rdata),   64'(0));
        check("rst_wait_if_rdata",  64'(if_rdata),    64'(0));
        check("rst_wait_stall_mem", 64'(stall_c_mem), 64'(0));
        model_reset();
        @(posedge clk);
        #1;
        mem_req = 1'b0; bus_rvalid = 1'b1; bus_rdata = 32'hBAD0_BAD0;
        run_cycle();
        rst = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            run_cycle();
            if (last_mem_done) done_cnt++;
        end
        check("rst_wait_no_done", 64'(done_cnt), 64'(0));
        idle_inputs();
        run_cycle();

        // Randomized traffic with spurious port strobes, redirects and resets.
        for (int n = 0; n < 4000; n++) begin
            if (mem_req && last_mem_done) begin
                mem_req = 1'b0;
            end else if (!mem_req && $urandom_range(0, 2) == 0) begin
                mem_req   = 1'b1;
                mem_we    = 1'($urandom_range(0, 1));
                mem_be    = BE_W'($urandom_range(0, 15));
                mem_addr  = $urandom() & 32'hFFFF_FFFC;
                mem_wdata = $urandom();
            end
            if (if_req && last_if_rvalid) begin
                if_req = 1'b0;
            end else if (!if_req && $urandom_range(0, 2) == 0) begin
                if_req  = 1'b1;
                if_addr = $urandom() & 32'hFFFF_FFFC;
            end
            flush_c_if = ($urandom_range(0, 7) == 0);
            if (flush_c_if && if_req) if_addr = $urandom() & 32'hFFFF_FFFC;
            bus_gnt    = 1'($urandom_range(0, 1));
            bus_rvalid = ($urandom_range(0, 2) == 0);
            bus_rdata  = $urandom();
            if (rst) begin
                rst_hold--;
                if (rst_hold <= 0) rst = 1'b0;
            end else if ($urandom_range(0, 299) == 0) begin
                rst = 1'b1;
                rst_hold = $urandom_range(1, 2);
                #1;
                check("rand_rst_bus_req", 64'(bus_req), 64'(0));
                check("rand_rst_pulses", 64'({if_rvalid, mem_done}), 64'(0));
            end
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
